// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle add/sub/logic/shift/compare, iterative radix-2 restoring divide.
// Latency: 1 cycle for simple ops; N+1 cycles for iterative ops (N = 32 when word, else XLEN).
// Backpressure: in_ready only in IDLE, one op in flight; result held in DONE until out_ready.
// Build option: define ALU_SEQ_MUL_EN to add the iterative shift-add multiplier on op 14.
module alu_seq #(
  parameter int XLEN = 64,
  parameter int OP_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OP_W-1:0] alu_op,
  input  logic            word,
  input  logic [XLEN-1:0] alu_src1,
  input  logic [XLEN-1:0] alu_src2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_res,
  output logic            zero
);

  localparam int SHW = $clog2(XLEN);
  localparam int CW  = $clog2(XLEN);

  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_AND  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_OR   = OP_W'(3);
  localparam logic [OP_W-1:0] OP_XOR  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_SLL  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_SRL  = OP_W'(6);
  localparam logic [OP_W-1:0] OP_SRA  = OP_W'(7);
  localparam logic [OP_W-1:0] OP_SLT  = OP_W'(8);
  localparam logic [OP_W-1:0] OP_SLTU = OP_W'(9);
  localparam logic [OP_W-1:0] OP_DIV  = OP_W'(10);
  localparam logic [OP_W-1:0] OP_DIVU = OP_W'(11);
  localparam logic [OP_W-1:0] OP_REM  = OP_W'(12);
  localparam logic [OP_W-1:0] OP_REMU = OP_W'(13);
`ifdef ALU_SEQ_MUL_EN
  localparam logic [OP_W-1:0] OP_MUL  = OP_W'(14);
`endif

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state, state_nxt;

  // Accept-side decode and operand preparation
  logic            word_eff, signed_op, start_iter;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] a_op, b_op, a_mag, b_mag, a_sx;
  logic [XLEN-1:0] sc_raw, sc_res;

  // Iteration registers: rem_q is the partial remainder (or product accumulator),
  // quot_q the shifting dividend/quotient (or multiplier), dvs_q the divisor (or multiplicand).
  logic [OP_W-1:0] op_q;
  logic            word_q, q_neg_q, r_neg_q, dz_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] rem_q, quot_q, dvs_q;
  logic [XLEN-1:0] rem_nxt, quot_nxt, dvs_nxt;
  logic [XLEN:0]   shifted, trial;
  logic [XLEN-1:0] q_fix, r_fix, it_raw, it_res;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Operand conditioning for the iterative unit: word truncation, signedness, magnitudes
  always_comb begin
    word_eff   = word && (XLEN == 64);
    signed_op  = (alu_op == OP_DIV) || (alu_op == OP_REM);
    a_op       = word_eff ? (signed_op ? sext32(alu_src1[31:0]) : XLEN'(alu_src1[31:0])) : alu_src1;
    b_op       = word_eff ? (signed_op ? sext32(alu_src2[31:0]) : XLEN'(alu_src2[31:0])) : alu_src2;
    a_mag      = (signed_op && a_op[XLEN-1]) ? -a_op : a_op;
    b_mag      = (signed_op && b_op[XLEN-1]) ? -b_op : b_op;
    start_iter = (alu_op >= OP_DIV) && (alu_op <= OP_REMU);
`ifdef ALU_SEQ_MUL_EN
    if (alu_op == OP_MUL) start_iter = 1'b1;
`endif
  end

  // Single-cycle result, computed from the request and registered at acceptance
  always_comb begin
    shamt  = word_eff ? SHW'(alu_src2[4:0]) : alu_src2[SHW-1:0];
    a_sx   = sext32(alu_src1[31:0]);
    sc_raw = '0;
    case (alu_op)
      OP_ADD:  sc_raw = alu_src1 + alu_src2;
      OP_SUB:  sc_raw = alu_src1 - alu_src2;
      OP_AND:  sc_raw = alu_src1 & alu_src2;
      OP_OR:   sc_raw = alu_src1 | alu_src2;
      OP_XOR:  sc_raw = alu_src1 ^ alu_src2;
      OP_SLL:  sc_raw = alu_src1 << shamt;
      OP_SRL:  sc_raw = word_eff ? (XLEN'(alu_src1[31:0]) >> shamt) : (alu_src1 >> shamt);
      OP_SRA:  sc_raw = word_eff ? XLEN'($signed(a_sx) >>> shamt) : XLEN'($signed(alu_src1) >>> shamt);
      OP_SLT:  sc_raw = XLEN'(word_eff ? ($signed(alu_src1[31:0]) < $signed(alu_src2[31:0]))
                                       : ($signed(alu_src1) < $signed(alu_src2)));
      OP_SLTU: sc_raw = XLEN'(word_eff ? (alu_src1[31:0] < alu_src2[31:0]) : (alu_src1 < alu_src2));
      default: sc_raw = '0;
    endcase
    // Compare results are plain 0/1; everything else wraps at 32 bits and sign-extends in word mode
    sc_res = (word_eff && (alu_op != OP_SLT) && (alu_op != OP_SLTU)) ? sext32(sc_raw[31:0]) : sc_raw;
  end

  // One restoring-divide step (or shift-add multiply step) from the iteration registers
  always_comb begin
    shifted  = {rem_q, quot_q[XLEN-1]};
    trial    = shifted - {1'b0, dvs_q};
    rem_nxt  = shifted[XLEN-1:0];
    quot_nxt = {quot_q[XLEN-2:0], 1'b0};
    dvs_nxt  = dvs_q;
    if (!trial[XLEN]) begin
      rem_nxt  = trial[XLEN-1:0];
      quot_nxt = {quot_q[XLEN-2:0], 1'b1};
    end
`ifdef ALU_SEQ_MUL_EN
    if (op_q == OP_MUL) begin
      rem_nxt  = rem_q + (quot_q[0] ? dvs_q : '0);
      quot_nxt = quot_q >> 1;
      dvs_nxt  = dvs_q << 1;
    end
`endif
  end

  // Final result of the iterative unit: sign fix-up, divide-by-zero override, word extension
  always_comb begin
    q_fix  = dz_q ? '1 : (q_neg_q ? -quot_nxt : quot_nxt);
    r_fix  = r_neg_q ? -rem_nxt : rem_nxt;
    it_raw = ((op_q == OP_DIV) || (op_q == OP_DIVU)) ? q_fix : r_fix;
`ifdef ALU_SEQ_MUL_EN
    if (op_q == OP_MUL) it_raw = rem_nxt;
`endif
    it_res = word_q ? sext32(it_raw[31:0]) : it_raw;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: simple ops go straight to DONE, iterative ops run in BUSY until the counter expires
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = start_iter ? BUSY : DONE;
      BUSY:    if (cnt_q == '0) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: capture at acceptance, iterate in BUSY, register the result into alu_res/zero
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_res <= '0;
      zero    <= 1'b1;
      cnt_q   <= '0;
      op_q    <= '0;
      word_q  <= 1'b0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      dz_q    <= 1'b0;
      rem_q   <= '0;
      quot_q  <= '0;
      dvs_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_q    <= alu_op;
            word_q  <= word_eff;
            cnt_q   <= word_eff ? CW'(31) : CW'(XLEN - 1);
            q_neg_q <= signed_op && (a_op[XLEN-1] ^ b_op[XLEN-1]);
            r_neg_q <= signed_op && a_op[XLEN-1];
            dz_q    <= (b_mag == '0);
            rem_q   <= '0;
            // Word divides left-align the 32-bit dividend so the step logic always shifts from the MSB
            quot_q  <= word_eff ? (a_mag << (XLEN - 32)) : a_mag;
            dvs_q   <= b_mag;
`ifdef ALU_SEQ_MUL_EN
            if (alu_op == OP_MUL) quot_q <= a_mag;
`endif
            if (!start_iter) begin
              alu_res <= sc_res;
              zero    <= (sc_res == '0);
            end
          end
        end
        BUSY: begin
          rem_q  <= rem_nxt;
          quot_q <= quot_nxt;
          dvs_q  <= dvs_nxt;
          if (cnt_q == '0) begin
            alu_res <= it_res;
            zero    <= (it_res == '0);
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_op;
  logic        word;
  logic [63:0] alu_src1;
  logic [63:0] alu_src2;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] alu_res;
  logic        zero;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_seq dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .word(word),
    .alu_src1(alu_src1), .alu_src2(alu_src2),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_res(alu_res), .zero(zero)
  );

  typedef struct {
    logic [3:0]  op;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t tv[$];

  task automatic add_vec(input logic [3:0] op, input logic w, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] exp, input int lat);
    vec_t v;
    v.op = op; v.w = w; v.a = a; v.b = b; v.exp = exp; v.lat = lat;
    tv.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %h, want %h", name, idx, got, exp);
    end
  endtask

  // Issue one request from a negedge in IDLE, wait for the result, then consume it.
  task automatic do_op(input logic [3:0] op, input logic w, input logic [63:0] a, input logic [63:0] b,
                       output logic [63:0] res, output logic z, output int lat, output int rdy_hits);
    int guard;
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_wait: in_ready still %b after %0d cycles, want 1", in_ready, guard);
    end
    alu_op = op; word = w; alu_src1 = a; alu_src2 = b; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    rdy_hits = 0;
    while (!out_valid && lat < 200) begin
      if (in_ready) rdy_hits++;
      @(negedge clk);
      lat++;
    end
    res = alu_res;
    z   = zero;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] res;
    logic        z;
    int          lat, hits, seen, bad;

    // ops: 0 ADD 1 SUB 2 AND 3 OR 4 XOR 5 SLL 6 SRL 7 SRA 8 SLT 9 SLTU 10 DIV 11 DIVU 12 REM 13 REMU 14 MUL 15 nop
    add_vec(4'd0,  1'b1, 64'hFFFF_FFFF, 64'd1, 64'd0, 1);
    add_vec(4'd0,  1'b0, 64'd5, 64'd7, 64'd12, 1);
    add_vec(4'd1,  1'b0, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 1);
    add_vec(4'd2,  1'b0, 64'hF0F0, 64'hFF00, 64'hF000, 1);
    add_vec(4'd3,  1'b0, 64'hF0F0, 64'h0F0F, 64'hFFFF, 1);
    add_vec(4'd4,  1'b0, 64'hFF, 64'h0F, 64'hF0, 1);
    add_vec(4'd5,  1'b0, 64'd1, 64'd127, 64'h8000_0000_0000_0000, 1);
    add_vec(4'd5,  1'b1, 64'd1, 64'h3F, 64'hFFFF_FFFF_8000_0000, 1);
    add_vec(4'd6,  1'b0, 64'h8000_0000_0000_0000, 64'd4, 64'h0800_0000_0000_0000, 1);
    add_vec(4'd6,  1'b1, 64'hFFFF_FFFF_8000_0000, 64'd4, 64'h0800_0000, 1);
    add_vec(4'd7,  1'b1, 64'h8000_0000, 64'd4, 64'hFFFF_FFFF_F800_0000, 1);
    add_vec(4'd7,  1'b0, 64'h8000_0000_0000_0000, 64'd4, 64'hF800_0000_0000_0000, 1);
    add_vec(4'd8,  1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1, 1);
    add_vec(4'd8,  1'b1, 64'h8000_0000, 64'd1, 64'd1, 1);
    add_vec(4'd9,  1'b0, 64'd1, 64'd2, 64'd1, 1);
    add_vec(4'd9,  1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1);
    add_vec(4'd15, 1'b0, 64'd5, 64'd7, 64'd0, 1);
    add_vec(4'd10, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    add_vec(4'd12, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    add_vec(4'd10, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    add_vec(4'd12, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 65);
    add_vec(4'd11, 1'b0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    add_vec(4'd13, 1'b0, 64'h1234, 64'd0, 64'h1234, 65);
    add_vec(4'd10, 1'b0, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    add_vec(4'd12, 1'b0, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB, 65);
    add_vec(4'd10, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 65);
    add_vec(4'd12, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 65);
    add_vec(4'd11, 1'b1, 64'd100, 64'd7, 64'd14, 33);
    add_vec(4'd13, 1'b1, 64'd100, 64'd7, 64'd2, 33);
    add_vec(4'd10, 1'b1, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33);
`ifdef ALU_SEQ_MUL_EN
    add_vec(4'd14, 1'b1, 64'hFFFF_FFFF, 64'd3, 64'hFFFF_FFFF_FFFF_FFFD, 33);
    add_vec(4'd14, 1'b0, 64'd6, 64'd7, 64'd42, 65);
`else
    add_vec(4'd14, 1'b1, 64'hFFFF_FFFF, 64'd3, 64'd0, 1);
    add_vec(4'd14, 1'b0, 64'd6, 64'd7, 64'd0, 1);
`endif

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    alu_op = 4'd0; word = 1'b0; alu_src1 = '0; alu_src2 = '0;
    repeat (2) @(negedge clk);
    chk("reset_in_ready", 0, 64'(in_ready), 64'd1);
    chk("reset_out_valid", 0, 64'(out_valid), 64'd0);
    chk("reset_res", 0, alu_res, 64'd0);
    chk("reset_zero", 0, 64'(zero), 64'd1);
    rst = 1'b0;
    @(negedge clk);

    foreach (tv[i]) begin
      do_op(tv[i].op, tv[i].w, tv[i].a, tv[i].b, res, z, lat, hits);
      chk("res", i, res, tv[i].exp);
      chk("zero", i, 64'(z), 64'(tv[i].exp == 64'd0));
      chk("latency", i, 64'(lat), 64'(tv[i].lat));
      if (tv[i].lat > 1) chk("busy_in_ready_hits", i, 64'(hits), 64'd0);
    end

    // Result held while the consumer stalls; a competing request waits for IDLE
    alu_op = 4'd0; word = 1'b0; alu_src1 = 64'd2; alu_src2 = 64'd3; in_valid = 1'b1;
    @(negedge clk);
    alu_op = 4'd1; alu_src1 = 64'd9; alu_src2 = 64'd1;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      if (!out_valid || in_ready || alu_res !== 64'd5) bad++;
      @(negedge clk);
    end
    chk("hold_unstable_cycles", 0, 64'(bad), 64'd0);
    chk("hold_res", 0, alu_res, 64'd5);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("b2b_idle_in_ready", 0, 64'(in_ready), 64'd1);
    chk("b2b_idle_out_valid", 0, 64'(out_valid), 64'd0);
    chk("b2b_idle_res", 0, alu_res, 64'd5);
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b_second_valid", 0, 64'(out_valid), 64'd1);
    chk("b2b_second_res", 0, alu_res, 64'd8);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset in the middle of a divide aborts it
    alu_op = 4'd11; word = 1'b0; alu_src1 = 64'd100; alu_src2 = 64'd3; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("busy_in_ready", 0, 64'(in_ready), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_in_ready", 0, 64'(in_ready), 64'd1);
    chk("abort_out_valid", 0, 64'(out_valid), 64'd0);
    chk("abort_res", 0, alu_res, 64'd0);
    chk("abort_zero", 0, 64'(zero), 64'd1);
    seen = 0;
    for (int k = 0; k < 80; k++) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    chk("abort_out_valid_cycles", 0, 64'(seen), 64'd0);

    do_op(4'd0, 1'b0, 64'd1, 64'd1, res, z, lat, hits);
    chk("post_abort_res", 0, res, 64'd2);
    chk("post_abort_latency", 0, 64'(lat), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter XLEN, default 64, datapath width in bits; legal values 32 and 64.
REQ-002 Parameter OP_W, default 4, width of the opcode port.
REQ-003 Port list, one per line: name  direction  width  meaning. The block SHALL use one clock (clk) and a synchronous, active-high reset (rst).
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request.
- alu_op  in  OP_W  operation code.
- word  in  1  when 1, 32-bit W variant: operate on low 32 bits, sign-extend result to XLEN; ignored when XLEN=32.
- alu_src1  in  XLEN  operand 1.
- alu_src2  in  XLEN  operand 2.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- alu_res  out  XLEN  result.
- zero  out  1  alu_res equals 0.

Function
REQ-004 Opcodes SHALL be: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 DIV, 11 DIVU, 12 REM, 13 REMU, 14 MUL; 15 yields result 0 with single-cycle latency.
REQ-005 A request SHALL be accepted only on a cycle where in_valid and in_ready are both 1; operands, op and word SHALL be captured that cycle.
REQ-006 FSM states SHALL be IDLE, BUSY, DONE:
- IDLE -> DONE on accepting an op in 0-9 or 15.
- IDLE -> BUSY on accepting an op in 10-14.
- BUSY -> DONE when the iteration counter expires.
- DONE -> IDLE when out_ready=1.
REQ-007 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-008 Single-cycle ops SHALL assert out_valid on the cycle after acceptance (latency 1).
REQ-009 DIV/DIVU/REM/REMU SHALL use a radix-2 restoring divider of N iterations (N=32 if word, else XLEN); out_valid SHALL rise N+1 cycles after acceptance.
REQ-010 Signed division SHALL operate on magnitudes and fix signs at completion: quotient negative iff operand signs differ; remainder takes the dividend's sign.
REQ-011 Divide by zero SHALL return quotient all-ones and remainder equal to the dividend, at full latency N+1.
REQ-012 Signed overflow (most-negative / -1) SHALL return quotient = most-negative and remainder 0.
REQ-013 Shift amount SHALL be alu_src2[4:0] when word=1 and alu_src2[$clog2(XLEN)-1:0] otherwise; SRA SHALL be arithmetic on the (word-truncated) operand.
REQ-014 ADD/SUB/logic/shift results SHALL wrap modulo 2^XLEN, or modulo 2^32 then sign-extend when word=1.
REQ-015 SLT/SLTU SHALL return 1 or 0, zero-extended; word=1 compares low 32 bits.
REQ-016 alu_res and zero SHALL be registered and held stable while out_valid=1 and out_ready=0.
REQ-017 in_valid while not in IDLE SHALL be ignored; the request is not lost because the requester holds it until in_ready.
REQ-018 Back-to-back: DONE with out_ready=1 returns to IDLE; the next request is accepted no earlier than the following cycle.

Reset
REQ-019 On rst=1 at a clock edge: state=IDLE, out_valid=0, alu_res=0, zero=1, counter=0, in_ready=1 on the next cycle.
REQ-020 rst asserted in BUSY or DONE SHALL abort the operation with no result delivered.

Configuration
REQ-021 Macro ALU_SEQ_MUL_EN defined:
- op 14 MUL is a shift-add multiplier of N iterations, latency N+1, returning the low XLEN bits of the product (low 32 bits sign-extended when word=1).
REQ-022 Macro ALU_SEQ_MUL_EN undefined:
- op 14 behaves as op 15 (result 0, latency 1).
- No multiplier hardware is present.

Verification
REQ-023 ADD, XLEN=64, src1=0xFFFF_FFFF, src2=1, word=1 -> alu_res=0, zero=1, out_valid one cycle after accept.
REQ-024 DIV, src1=-7, src2=2 -> alu_res=-3 at cycle 65; REM same operands -> alu_res=-1; in_ready=0 throughout BUSY.
REQ-025 DIVU, src2=0, src1=0x1234 -> 0xFFFF_FFFF_FFFF_FFFF; REMU -> 0x1234; DIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000.
REQ-026 SRA, word=1, src1=0x8000_0000, src2=4 -> 0xFFFF_FFFF_F800_0000; SLTU 1 vs 2 -> 1.
REQ-027 Hold out_ready=0 for 5 cycles in DONE -> alu_res stable, second request not accepted; rst during BUSY of a DIV -> out_valid never rises, in_ready=1 the cycle after reset.
REQ-028 With ALU_SEQ_MUL_EN, MUL 0xFFFF_FFFF * 3, word=1 -> 0xFFFF_FFFF_FFFF_FFFD after 33 cycles; without the macro -> 0 after 1 cycle.
